// File: rtl/usb_cmd_pkg.sv
// Shared types and constants for the USB command engine.
// Optional macro USB_CMD_TIMEOUT_EN adds the StDrain state used after a write timeout.
package usb_cmd_pkg;

  // Command opcodes carried in header word 0 bits [31:28]
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  // Status codes reported in the top nibble of the status word
  localparam logic [3:0] ST_OK      = 4'hA;
  localparam logic [3:0] ST_BADOP   = 4'hE;
  localparam logic [3:0] ST_TIMEOUT = 4'hF;

  typedef enum logic [3:0] {
    StHdr0,
    StHdr1,
    StWrData,
    StWrReq,
    StWrNext,
    StRdReq,
    StRdPush,
    StStatus
`ifdef USB_CMD_TIMEOUT_EN
    ,
    StDrain
`endif
  } state_e;

  // Status word: {code, opcode, 8'h00, completed word count}
  function automatic logic [31:0] status_word(input logic [3:0]  code,
                                              input logic [3:0]  opcode,
                                              input logic [15:0] done);
    return {code, opcode, 8'h00, done};
  endfunction

endpackage

// File: rtl/usb_cmd_engine.sv
// USB-side command engine: parses host command stream into single-word mux
// requests and returns read data plus a per-command status word.
// Optional macro USB_CMD_TIMEOUT_EN enables a request watchdog of TIMEOUT_CYCLES
// cycles; on expiry the request drops, err sets, and unsent write payload is drained.
module usb_cmd_engine
  import usb_cmd_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        usb_rd,
  output logic        usb_wr,
  output logic [25:0] usb_addr,
  output logic [31:0] usb_wr_data,
  input  logic [31:0] usb_rd_data,
  input  logic        usb_rd_valid,
  input  logic        usb_wr_ready,
  output logic        busy,
  output logic        err
);

  state_e             r_state;
  state_e             w_next_state;
  logic [3:0]         r_opcode;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_done;
  logic [25:0]        r_addr;
  logic [3:0]         r_code;
  logic               r_err;
  logic               r_wr;
  logic               r_rd_req;
  logic [31:0]        r_wr_data;
  logic [31:0]        r_rd_data;

  logic               w_rx_fire;
  logic               w_tx_fire;
  logic               w_bad_op;
  logic               w_last;
  logic               w_timeout;

  assign w_rx_fire = rx_valid & rx_ready;
  assign w_tx_fire = tx_valid & tx_ready;
  assign w_bad_op  = (r_opcode != OP_WRITE) && (r_opcode != OP_READ);
  // The word being retired is the final one of the command
  assign w_last    = (r_done + LEN_W'(1)) == r_len;

`ifdef USB_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [LEN_W-1:0] r_drain_left;

  assign w_timeout = ((r_state == StWrReq) || (r_state == StRdReq)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // Watchdog restarts on every state entry and counts only while a request is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == StWrReq) || (r_state == StRdReq)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Remaining payload words to discard after a write timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_left <= '0;
    end else if ((r_state == StWrReq) && !usb_wr_ready && w_timeout) begin
      r_drain_left <= r_len - r_done - LEN_W'(1);
    end else if ((r_state == StDrain) && w_rx_fire) begin
      r_drain_left <= r_drain_left - LEN_W'(1);
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  // Request outputs; read drops combinationally on the valid pulse so the mux,
  // already back in idle that cycle, never sees a duplicate request
  assign usb_wr      = r_wr & ~w_timeout;
  assign usb_rd      = r_rd_req & ~usb_rd_valid & ~w_timeout;
  assign usb_addr    = r_addr;
  assign usb_wr_data = r_wr_data;
  assign busy        = (r_state != StHdr0);
  assign err         = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StHdr0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StHdr0: begin
        if (w_rx_fire) w_next_state = StHdr1;
      end
      StHdr1: begin
        if (w_rx_fire) begin
          if (w_bad_op || (r_len == '0)) begin
            w_next_state = StStatus;
          end else if (r_opcode == OP_WRITE) begin
            w_next_state = StWrData;
          end else begin
            w_next_state = StRdReq;
          end
        end
      end
      StWrData: begin
        if (w_rx_fire) w_next_state = StWrReq;
      end
      StWrReq: begin
        if (usb_wr_ready) begin
          w_next_state = StWrNext;
`ifdef USB_CMD_TIMEOUT_EN
        end else if (w_timeout) begin
          w_next_state = ((r_len - r_done - LEN_W'(1)) == '0) ? StStatus : StDrain;
`endif
        end
      end
      StWrNext: begin
        w_next_state = w_last ? StStatus : StWrData;
      end
      StRdReq: begin
        if (usb_rd_valid) begin
          w_next_state = StRdPush;
`ifdef USB_CMD_TIMEOUT_EN
        end else if (w_timeout) begin
          w_next_state = StStatus;
`endif
        end
      end
      StRdPush: begin
        if (w_tx_fire) w_next_state = w_last ? StStatus : StRdReq;
      end
      StStatus: begin
        if (w_tx_fire) w_next_state = StHdr0;
      end
`ifdef USB_CMD_TIMEOUT_EN
      StDrain: begin
        if (w_rx_fire && (r_drain_left == LEN_W'(1))) w_next_state = StStatus;
      end
`endif
      default: w_next_state = StHdr0;
    endcase
  end

  // Stream handshake outputs and transmit word selection
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (r_state)
      StHdr0, StHdr1, StWrData: rx_ready = 1'b1;
`ifdef USB_CMD_TIMEOUT_EN
      StDrain: rx_ready = 1'b1;
`endif
      StRdPush: begin
        tx_valid = 1'b1;
        tx_data  = r_rd_data;
      end
      StStatus: begin
        tx_valid = 1'b1;
        tx_data  = status_word(r_code, r_opcode, 16'(r_done));
      end
      default: ;
    endcase
  end

  // Command datapath: header fields, address/count progression, request flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode  <= '0;
      r_len     <= '0;
      r_done    <= '0;
      r_addr    <= '0;
      r_code    <= '0;
      r_err     <= 1'b0;
      r_wr      <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wr_data <= '0;
      r_rd_data <= '0;
    end else begin
      unique case (r_state)
        StHdr0: begin
          if (w_rx_fire) begin
            r_opcode <= rx_data[31:28];
            r_len    <= rx_data[LEN_W-1:0];
            r_err    <= 1'b0;
          end
        end
        StHdr1: begin
          if (w_rx_fire) begin
            r_addr <= {rx_data[25:2], 2'b00};
            r_done <= '0;
            if (w_bad_op) begin
              r_err  <= 1'b1;
              r_code <= ST_BADOP;
            end else begin
              r_code <= ST_OK;
              if ((r_len != '0) && (r_opcode == OP_READ)) r_rd_req <= 1'b1;
            end
          end
        end
        StWrData: begin
          if (w_rx_fire) begin
            r_wr_data <= rx_data;
            r_wr      <= 1'b1;
          end
        end
        StWrReq: begin
          if (usb_wr_ready) begin
            r_wr <= 1'b0;
          end else if (w_timeout) begin
            r_wr   <= 1'b0;
            r_err  <= 1'b1;
            r_code <= ST_TIMEOUT;
          end
        end
        StWrNext: begin
          r_addr <= r_addr + 26'd4;
          r_done <= r_done + LEN_W'(1);
        end
        StRdReq: begin
          if (usb_rd_valid) begin
            r_rd_data <= usb_rd_data;
            r_rd_req  <= 1'b0;
          end else if (w_timeout) begin
            r_rd_req <= 1'b0;
            r_err    <= 1'b1;
            r_code   <= ST_TIMEOUT;
          end
        end
        StRdPush: begin
          if (w_tx_fire) begin
            r_addr <= r_addr + 26'd4;
            r_done <= r_done + LEN_W'(1);
            if (!w_last) r_rd_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_engine.sv
// Scoreboard bench for usb_cmd_engine: stimulus pushes expected mux requests and
// tx words into queues; a monitor pops and compares as the DUT presents them.
module tb_usb_cmd_engine;

`ifdef USB_CMD_TIMEOUT_EN
  localparam int unsigned TB_TMO = 16;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        usb_rd;
  logic        usb_wr;
  logic [25:0] usb_addr;
  logic [31:0] usb_wr_data;
  logic [31:0] usb_rd_data;
  logic        usb_rd_valid;
  logic        usb_wr_ready;
  logic        busy;
  logic        err;

  usb_cmd_engine #(
    .LEN_W          (16),
    .TIMEOUT_CYCLES (TB_TMO)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .usb_rd       (usb_rd),
    .usb_wr       (usb_wr),
    .usb_addr     (usb_addr),
    .usb_wr_data  (usb_wr_data),
    .usb_rd_data  (usb_rd_data),
    .usb_rd_valid (usb_rd_valid),
    .usb_wr_ready (usb_wr_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [25:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_tx[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic is_wr, input logic [25:0] addr, input logic [31:0] data);
    req_t r;
    r.is_wr = is_wr;
    r.addr  = addr;
    r.data  = data;
    exp_req.push_back(r);
  endtask

  // Called at posedge+2; returns at posedge+2 after the word is taken
  task automatic send(input logic [31:0] d);
    int n = 0;
    rx_data  = d;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 200) break;
    end
    checks++;
    if (n > 200) begin
      errors++;
      $display("FAIL rx_accept: word %0h not accepted within 200 cycles", d);
    end
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 64'(n < 1000), 64'd1);
    @(posedge clk);
    #2;
  endtask

  // Mux model: ack writes / return reads two cycles after the request is seen
  int   wr_cnt  = 0;
  int   rd_cnt  = 0;
  int   wr_seen = 0;
  int   nack_at = -1;
  logic nxt_wr;
  logic nxt_rd;
  logic mux_prev_wr = 1'b0;

  initial begin
    usb_wr_ready = 1'b0;
    usb_rd_valid = 1'b0;
    usb_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (usb_wr && !mux_prev_wr) wr_seen++;
      mux_prev_wr = usb_wr;
      if (usb_wr && !usb_wr_ready) wr_cnt++; else wr_cnt = 0;
      if (usb_rd && !usb_rd_valid) rd_cnt++; else rd_cnt = 0;
      nxt_wr = (wr_cnt == 2) && (wr_seen != nack_at);
      nxt_rd = (rd_cnt == 2);
      @(posedge clk);
      #2;
      usb_wr_ready = nxt_wr;
      usb_rd_valid = nxt_rd;
      if (nxt_wr) wr_cnt = 0;
      if (nxt_rd) begin
        rd_cnt      = 0;
        usb_rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: request scoreboard, tx scoreboard, handshake rules
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;
  int          run = 0;
  int          last_run = 0;
  req_t        r;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (usb_wr || usb_rd) check("rd_wr_exclusive", 64'(usb_wr & usb_rd), 64'd0);
        if (usb_rd_valid) check("rd_low_in_valid", 64'(usb_rd), 64'd0);
        if (tx_valid) check("no_rd_during_tx", 64'(usb_rd), 64'd0);
        if ((usb_wr && !prev_wr) || (usb_rd && !prev_rd)) begin
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: wr=%0b rd=%0b addr %0h", usb_wr, usb_rd, usb_addr);
          end else begin
            r = exp_req.pop_front();
            if ((usb_wr !== r.is_wr) || (usb_addr !== r.addr) ||
                (r.is_wr && (usb_wr_data !== r.data))) begin
              errors++;
              $display("FAIL req: got wr=%0b addr %0h data %0h expected wr=%0b addr %0h data %0h",
                       usb_wr, usb_addr, usb_wr_data, r.is_wr, r.addr, r.data);
            end
          end
        end
        if (usb_wr) run++;
        else begin
          if (run != 0) last_run = run;
          run = 0;
        end
        if (hold) begin
          check("tx_hold_valid", 64'(tx_valid), 64'd1);
          check("tx_hold_data", 64'(tx_data), 64'(hold_data));
        end
        hold      = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got %0h", tx_data);
          end else begin
            check("tx_word", 64'(tx_data), 64'(exp_tx.pop_front()));
          end
        end
      end else begin
        hold = 1'b0;
        run  = 0;
      end
      prev_wr = usb_wr;
      prev_rd = usb_rd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_usb_rd", 64'(usb_rd), 64'd0);
    check("rst_usb_wr", 64'(usb_wr), 64'd0);
    check("rst_usb_addr", 64'(usb_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #2;

    // WRITE N=3 at 0x100
    push_req(1'b1, 26'h100, 32'h11);
    push_req(1'b1, 26'h104, 32'h22);
    push_req(1'b1, 26'h108, 32'h33);
    exp_tx.push_back(32'hA100_0003);
    send(32'h1000_0003);
    send(32'h0000_0100);
    send(32'h11);
    @(negedge clk);
    check("wr_latency", 64'(usb_wr), 64'd1);
    @(posedge clk);
    #2;
    send(32'h22);
    send(32'h33);
    wait_done("write3");

    // READ N=2 at top of address space; upper and low address bits ignored
    rd_q.push_back(32'hAAAA_5555);
    rd_q.push_back(32'h1234_5678);
    push_req(1'b0, 26'h3FF_FFFC, '0);
    push_req(1'b0, 26'h000_0000, '0);
    exp_tx.push_back(32'hAAAA_5555);
    exp_tx.push_back(32'h1234_5678);
    exp_tx.push_back(32'hA200_0002);
    send(32'h2000_0002);
    send(32'hFFFF_FFFF);
    @(negedge clk);
    check("rd_latency", 64'(usb_rd), 64'd1);
    @(posedge clk);
    #2;
    wait_done("read_wrap");

    // READ N=2 with tx back-pressure
    rd_q.push_back(32'hDEAD_BEEF);
    rd_q.push_back(32'hCAFE_F00D);
    push_req(1'b0, 26'h40, '0);
    push_req(1'b0, 26'h44, '0);
    exp_tx.push_back(32'hDEAD_BEEF);
    exp_tx.push_back(32'hCAFE_F00D);
    exp_tx.push_back(32'hA200_0002);
    tx_ready = 1'b0;
    send(32'h2000_0002);
    send(32'h0000_0040);
    repeat (15) @(posedge clk);
    #2;
    check("bp_tx_valid", 64'(tx_valid), 64'd1);
    check("bp_addr_held", 64'(usb_addr), 64'h40);
    tx_ready = 1'b1;
    wait_done("read_backpressure");

    // Bad opcode 7, N=5
    exp_tx.push_back(32'hE700_0000);
    send(32'h7000_0005);
    send(32'h0000_0000);
    @(negedge clk);
    check("badop_err", 64'(err), 64'd1);
    @(posedge clk);
    #2;
    wait_done("badop");
    check("badop_err_sticky", 64'(err), 64'd1);
    check("badop_next_ready", 64'(rx_ready), 64'd1);

    // WRITE N=0: header accept clears err, no mux write
    exp_tx.push_back(32'hA100_0000);
    send(32'h1000_0000);
    check("err_cleared", 64'(err), 64'd0);
    send(32'h0000_0200);
    wait_done("write_n0");

    // Reset mid-command: write stalled by mux, then reset, no status word
    push_req(1'b1, 26'h300, 32'h55);
    nack_at = wr_seen + 1;
    send(32'h1000_0002);
    send(32'h0000_0300);
    send(32'h55);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_usb_wr", 64'(usb_wr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tx_valid", 64'(tx_valid), 64'd0);
    rst = 1'b0;
    nack_at = -1;
    repeat (3) @(posedge clk);
    #2;

`ifdef USB_CMD_TIMEOUT_EN
    // WRITE N=4; second word never acknowledged
    push_req(1'b1, 26'h500, 32'h1);
    push_req(1'b1, 26'h504, 32'h2);
    exp_tx.push_back(32'hF100_0001);
    nack_at = wr_seen + 2;
    send(32'h1000_0004);
    send(32'h0000_0500);
    send(32'h1);
    send(32'h2);
    send(32'h3);
    send(32'h4);
    wait_done("timeout");
    check("timeout_wr_cycles", 64'(last_run), 64'd16);
    check("timeout_err", 64'(err), 64'd1);
    nack_at = -1;
`endif

    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    check("rd_data_used", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
